dro_pulse_driver: RTL

Clocked driver that serializes a parallel word into SFQ-style return-to-zero pulse pairs for a destructive-readout (DRO) storage cell: per bit, an optional data pulse on `dro_d`, then a clock pulse on `dro_clk` after a programmable setup interval, then a recovery gap. It is the writer/initiator side of the DRO `d`/`clk` pulse interface, used in the functional RSFQ library benches and accumulator datapaths to load and strobe DRO cells with guaranteed setup/hold spacing. An optional readback path captures the DRO `out` pulses and compares them with the transmitted word.

---
 rtl/dro_drv_pkg.sv | 20 ++
 rtl/dro_readback_sampler.sv | 67 ++++++
 rtl/dro_pulse_driver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/dro_drv_pkg.sv
// Shared types and helpers for the DRO pulse driver.
// Optional readback path is enabled with DRO_READBACK_EN.
package dro_drv_pkg;

  localparam int DRO_DRV_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    DPULSE,
    SETUP,
    CPULSE,
    GAP,
    FIN
  } dro_drv_state_t;

  function automatic int bit_period(input int d_to_clk, input int pulse_w, input int clk_gap);
    return d_to_clk + pulse_w + clk_gap;
  endfunction

endpackage

// File: rtl/dro_readback_sampler.sv
// Captures DRO output pulses per bit period and compares against the sent word.
// Only built when DRO_READBACK_EN is defined.
`ifdef DRO_READBACK_EN
module dro_readback_sampler
  import dro_drv_pkg::*;
#(
  parameter int W        = 8,
  parameter int D_TO_CLK = 4,
  parameter int T        = 9,
  parameter int PH_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            accept_i,
  input  logic [W-1:0]    word_i,
  input  logic            in_word_i,
  input  logic [PH_W-1:0] ph_i,
  input  logic            fin_i,
  input  logic            dro_out_i,
  output logic [W-1:0]    rd_data_o,
  output logic            rd_err_o
);

  localparam logic [PH_W-1:0] PH_WIN  = PH_W'(D_TO_CLK);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(T - 1);

  logic [W-1:0] sent_q, cap_q, rd_data_q;
  logic         acc_q, rd_err_q;
  logic [W:0]   cat;
  logic [W-1:0] cap_d;

  // The bit being closed enters at the MSB so bit 0 ends at the LSB after W shifts.
  assign cat   = {acc_q, cap_q};
  assign cap_d = cat[W:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sent_q    <= '0;
      cap_q     <= '0;
      acc_q     <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      if (accept_i) begin
        sent_q <= word_i;
        cap_q  <= '0;
        acc_q  <= 1'b0;
      end else if (in_word_i) begin
        if (ph_i == PH_LAST) begin
          cap_q <= cap_d;
          acc_q <= 1'b0;
        end else if (ph_i >= PH_WIN) begin
          acc_q <= acc_q | dro_out_i;
        end
      end
      if (fin_i) begin
        rd_data_q <= cap_d;
        rd_err_q  <= (cap_d != sent_q);
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_err_o  = rd_err_q;

endmodule
`endif

// File: rtl/dro_pulse_driver.sv
// Serializes a word LSB first into d/clk return-to-zero pulse pairs for a DRO cell.
// Define DRO_READBACK_EN to add the dro_out capture and compare path.
module dro_pulse_driver
  import dro_drv_pkg::*;
#(
  parameter int W        = 8,
  parameter int PULSE_W  = 2,
  parameter int D_TO_CLK = 4,
  parameter int CLK_GAP  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         dro_d,
  output logic         dro_clk,
  output logic         busy,
  output logic         done
`ifdef DRO_READBACK_EN
  ,
  input  logic         dro_out,
  output logic [W-1:0] rd_data,
  output logic         rd_err
`endif
);

  localparam int T    = bit_period(D_TO_CLK, PULSE_W, CLK_GAP);
  localparam int PH_W = $clog2(T + 1);
  localparam int BI_W = $clog2(W + 1);

  localparam logic [PH_W-1:0] PH_SETUP = PH_W'(PULSE_W);
  localparam logic [PH_W-1:0] PH_CLK   = PH_W'(D_TO_CLK);
  localparam logic [PH_W-1:0] PH_GAP   = PH_W'(D_TO_CLK + PULSE_W);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(T - 1);
  localparam logic [BI_W-1:0] BI_LAST  = BI_W'(W - 1);

  if (W < 1 || W > DRO_DRV_MAX_W) begin : g_bad_w
    $error("dro_pulse_driver: W out of range");
  end
  if (PULSE_W < 1) begin : g_bad_pw
    $error("dro_pulse_driver: PULSE_W must be >= 1");
  end
  if (D_TO_CLK < PULSE_W) begin : g_bad_dc
    $error("dro_pulse_driver: D_TO_CLK must be >= PULSE_W");
  end
  if (CLK_GAP < 1) begin : g_bad_gap
    $error("dro_pulse_driver: CLK_GAP must be >= 1");
  end

  dro_drv_state_t  state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d, ph_inc;
  logic [BI_W-1:0] bit_q, bit_d;
  logic [W-1:0]    sh_q, sh_d;
  logic            dro_d_q, dro_clk_q, busy_q, done_q, in_ready_q;
  logic            accept, in_word;

  assign accept  = (state_q == IDLE) && in_valid && in_ready_q;
  assign in_word = (state_q == DPULSE) || (state_q == SETUP) ||
                   (state_q == CPULSE) || (state_q == GAP);
  assign ph_inc  = ph_q + 1'b1;

  // ph_q is the position within the current bit period; sub-states follow from it,
  // so a zero-length SETUP falls out of the decode with no special case.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = in_data;
          bit_d   = '0;
          ph_d    = '0;
          state_d = DPULSE;
        end
      end
      FIN: state_d = IDLE;
      default: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (bit_q == BI_LAST) begin
            state_d = FIN;
          end else begin
            sh_d    = sh_q >> 1;
            bit_d   = bit_q + 1'b1;
            state_d = DPULSE;
          end
        end else begin
          ph_d = ph_inc;
          if (ph_inc < PH_SETUP)    state_d = DPULSE;
          else if (ph_inc < PH_CLK) state_d = SETUP;
          else if (ph_inc < PH_GAP) state_d = CPULSE;
          else                      state_d = GAP;
        end
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      dro_d_q    <= 1'b0;
      dro_clk_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      dro_d_q    <= (state_d == DPULSE) && sh_d[0];
      dro_clk_q  <= (state_d == CPULSE);
      busy_q     <= (state_d == DPULSE) || (state_d == SETUP) ||
                    (state_d == CPULSE) || (state_d == GAP);
      done_q     <= (state_d == FIN);
      in_ready_q <= (state_d == IDLE);
    end
  end

  assign dro_d    = dro_d_q;
  assign dro_clk  = dro_clk_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign in_ready = in_ready_q;

`ifdef DRO_READBACK_EN
  dro_readback_sampler #(
    .W        (W),
    .D_TO_CLK (D_TO_CLK),
    .T        (T),
    .PH_W     (PH_W)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .accept_i  (accept),
    .word_i    (in_data),
    .in_word_i (in_word),
    .ph_i      (ph_q),
    .fin_i     (state_d == FIN),
    .dro_out_i (dro_out),
    .rd_data_o (rd_data),
    .rd_err_o  (rd_err)
  );
`else
  logic unused_in_word;
  assign unused_in_word = in_word;
`endif

endmodule
